// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction-fetch prefetch unit.
// Contents: default address width, PC increment, alignment mask and the
// {pc, instruction} entry layout used by consumers at the default width.
package ifetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned PC_STEP      = 4;
  // Low PC bits that are forced to zero on a redirect.
  localparam int unsigned ALIGN_MASK   = PC_STEP - 1;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a registered head word.
// Ports: clk, rst_n (async active-low), flush (drop all entries), push/wdata,
// pop, rdata (head entry, holds last value while empty, 0 after reset),
// empty, full, count.
// Push and pop in the same cycle are accepted at any occupancy.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rdata_q;

  logic             do_push;
  logic             do_pop;
  logic [AW-1:0]    rd_ptr_n;
  logic [CW-1:0]    remain;
  logic [CW-1:0]    count_n;
  logic [WIDTH-1:0] rdata_n;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = rdata_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next head: oldest surviving stored entry, else the word being pushed, else hold.
  always_comb begin
    rd_ptr_n = rd_ptr_q + AW'(do_pop);
    remain   = count_q - CW'(do_pop);
    count_n  = remain + CW'(do_push);
    rdata_n  = rdata_q;
    if (remain != '0) begin
      rdata_n = mem_q[rd_ptr_n];
    end else if (do_push) begin
      rdata_n = wdata;
    end
  end

  // Pointer, count and head register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_n;
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      count_q  <= count_n;
      rdata_q  <= rdata_n;
    end
  end

  // Storage; only slots covered by count are ever read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/ifetch_prefetch_unit.sv
// Instruction-fetch front end with a DEPTH-entry prefetch queue.
// Ports: CLK, RESET (async active-low); redirect_valid/redirect_pc from branch
// resolution; imem_req_valid/ready/addr request channel; imem_rsp_valid/data
// in-order responses; out_valid/out_ready with out_pc, out_pc4, out_instruction
// towards decode.
// Optional build macro IFETCH_PERF_CNT_EN adds perf_fetched (pops) and
// perf_dropped (killed responses) counters.
module ifetch_prefetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4,
  output logic [XLEN-1:0] out_instruction
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned QW = 3 * XLEN;

  logic [XLEN-1:0] fetch_pc_q;
  logic [CW-1:0]   kill_cnt_q;
  logic [CW-1:0]   occupancy;
  logic [CW-1:0]   outstanding;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_drop;
  logic            q_push;
  logic            q_pop;
  logic            q_empty;
  logic            q_full;
  logic            pcf_empty;
  logic            pcf_full;
  logic [XLEN-1:0] rsp_pc;
  logic [QW-1:0]   q_wdata;
  logic [QW-1:0]   q_rdata;
  logic            unused_fifo_flags;

  // Queued entries plus requests in flight may never exceed DEPTH.
  assign credit_used    = (CW+1)'(occupancy) + (CW+1)'(outstanding);
  assign imem_req_valid = RESET && (credit_used < (CW+1)'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses owed to a squashed path, or landing in a redirect cycle, are discarded.
  assign rsp_drop = imem_rsp_valid && (redirect_valid || (kill_cnt_q != '0));
  assign q_push   = imem_rsp_valid && !rsp_drop;
  assign q_wdata  = {rsp_pc, rsp_pc + XLEN'(PC_STEP), imem_rsp_data};

  assign out_valid = !q_empty && !redirect_valid;
  assign q_pop     = out_valid && out_ready;
  assign {out_pc, out_pc4, out_instruction} = q_rdata;

  assign unused_fifo_flags = ^{q_full, pcf_empty, pcf_full};

  // Decode-side queue of {pc, pc+4, instruction}.
  fetch_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_out_queue (
    .clk   (CLK),
    .rst_n (RESET),
    .flush (redirect_valid),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .rdata (q_rdata),
    .empty (q_empty),
    .full  (q_full),
    .count (occupancy)
  );

  // PCs of accepted requests, retired one per response whether kept or dropped.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_inflight_pc (
    .clk   (CLK),
    .rst_n (RESET),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (fetch_pc_q),
    .pop   (imem_rsp_valid),
    .rdata (rsp_pc),
    .empty (pcf_empty),
    .full  (pcf_full),
    .count (outstanding)
  );

  // Next fetch address; a redirect overrides any increment.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc & ~XLEN'(ALIGN_MASK);
    end else if (req_fire) begin
      fetch_pc_q <= fetch_pc_q + XLEN'(PC_STEP);
    end
  end

  // Responses still to be squashed; the last redirect recomputes from what is in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      kill_cnt_q <= '0;
    end else if (redirect_valid) begin
      kill_cnt_q <= outstanding - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (kill_cnt_q != '0)) begin
      kill_cnt_q <= kill_cnt_q - CW'(1);
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Free-running event counters.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(q_pop);
      perf_dropped <= perf_dropped + 32'(rsp_drop);
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Scoreboard bench for ifetch_prefetch_unit: a behavioural memory with
// configurable latency, a directed stimulus thread, and a monitor that
// compares every decode-side pop against the expected-entry queue.
module tb_ifetch_prefetch_unit;
  import ifetch_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc4;
  logic [XLEN-1:0] out_instruction;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_dropped;
`endif

  ifetch_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_pc4         (out_pc4),
    .out_instruction (out_instruction)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_dropped    (perf_dropped)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           mem_lat = 1;
  int           req_fire_cnt = 0;
  int           pop_cnt = 0;
  int           first_pop_cyc = 0;
  int           last_pop_cyc = 0;
  pend_t        pend_q[$];
  fetch_entry_t exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic fetch_entry_t entry(input logic [31:0] a);
    fetch_entry_t e;
    e.pc          = a;
    e.instruction = instr_of(a);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: always ready, one in-order response per accepted request after mem_lat cycles.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge CLK);
      if (RESET && pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(pend_q[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
      end
      #2;
      if (!RESET) begin
        pend_q.delete();
        imem_rsp_valid = 1'b0;
      end else begin
        if (imem_rsp_valid) void'(pend_q.pop_front());
        if (imem_req_valid && imem_req_ready) begin
          pend_t p;
          p.addr = imem_req_addr;
          p.due  = cyc + mem_lat;
          pend_q.push_back(p);
          req_fire_cnt++;
        end
      end
    end
  end

  // Monitor: every accepted decode entry is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (RESET && out_valid && out_ready) begin
        pop_cnt++;
        if (pop_cnt == 1) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pop: got out_pc %h expected no entry", out_pc);
        end else begin
          fetch_entry_t e;
          e = exp_q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_pc4", out_pc4, e.pc + 32'd4);
          check("out_instruction", out_instruction, e.instruction);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge CLK);
    #1;
    RESET          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    repeat (2) @(negedge CLK);
    exp_q.delete();
    pop_cnt      = 0;
    req_fire_cnt = 0;
    #1;
    RESET = 1'b1;
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 200 && pop_cnt < n; i++) @(negedge CLK);
    check("pop_count", 32'(pop_cnt), 32'(n));
  endtask

  initial begin
    RESET          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b1;

    // Reset state while RESET is held.
    #12;
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_pc4", out_pc4, 0);
    check("rst_out_instr", out_instruction, 0);

    // Streaming with 1-cycle memory: 1 instruction per cycle from RESET_PC.
    apply_reset();
    mem_lat   = 1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(entry(32'(i * 4)));
    #2;
    check("first_req_valid", 32'(imem_req_valid), 1);
    check("first_req_addr", imem_req_addr, 32'h0);
    wait_pops(8);
    out_ready = 1'b0;
    check("stream_throughput", 32'(last_pop_cyc - first_pop_cyc), 7);
    check("stream_drain", 32'(exp_q.size()), 0);
`ifdef IFETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 8);
`endif

    // Backpressure: DEPTH credits, then one pop frees one credit a cycle later.
    apply_reset();
    mem_lat = 1;
    repeat (10) @(negedge CLK);
    #3;
    check("full_req_count", 32'(req_fire_cnt), 4);
    check("full_req_valid", 32'(imem_req_valid), 0);
    check("full_out_valid", 32'(out_valid), 1);
    exp_q.push_back(entry(32'h0));
    @(negedge CLK);
    out_ready = 1'b1;
    #3;
    check("pop_no_same_cycle_credit", 32'(imem_req_valid), 0);
    @(negedge CLK);
    out_ready = 1'b0;
    #3;
    check("pop_credit_next_cycle", 32'(imem_req_valid), 1);
    check("pop_credit_addr", imem_req_addr, 32'h10);
    repeat (6) @(negedge CLK);
    #3;
    check("one_extra_request", 32'(req_fire_cnt), 5);
    check("full_again", 32'(imem_req_valid), 0);
    check("bp_drain", 32'(exp_q.size()), 0);

    // 3-cycle memory, redirect with two requests in flight.
    apply_reset();
    mem_lat = 3;
    for (int i = 0; i < 4; i++) exp_q.push_back(entry(32'h100 + 32'(i * 4)));
    repeat (2) @(negedge CLK);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #3;
    check("redirect_blocks_req", 32'(imem_req_valid), 0);
    @(negedge CLK);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    #3;
    check("redirect_target_addr", imem_req_addr, 32'h100);
    wait_pops(4);
    out_ready = 1'b0;
    check("kill_drain", 32'(exp_q.size()), 0);
`ifdef IFETCH_PERF_CNT_EN
    check("perf_dropped_two", perf_dropped, 2);
`endif

    // Redirect in the same cycle as a response and a ready decode stage.
    apply_reset();
    mem_lat   = 1;
    out_ready = 1'b1;
    exp_q.push_back(entry(32'h0));
    for (int i = 0; i < 3; i++) exp_q.push_back(entry(32'h40 + 32'(i * 4)));
    repeat (3) @(negedge CLK);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #3;
    check("redirect_hides_out_valid", 32'(out_valid), 0);
    @(negedge CLK);
    redirect_valid = 1'b0;
    wait_pops(4);
    out_ready = 1'b0;
    check("coincide_drain", 32'(exp_q.size()), 0);
`ifdef IFETCH_PERF_CNT_EN
    check("perf_dropped_one", perf_dropped, 1);
`endif

    // Alignment, back-to-back redirects and address wrap.
    apply_reset();
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #2;
    check("redirect_cycle_no_req", 32'(imem_req_valid), 0);
    @(negedge CLK);
    redirect_valid = 1'b0;
    #3;
    check("aligned_addr", imem_req_addr, 32'h200);
    check("aligned_req_valid", 32'(imem_req_valid), 1);
    @(negedge CLK);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge CLK);
    redirect_pc    = 32'hFFFF_FFFF;
    exp_q.push_back(entry(32'hFFFF_FFFC));
    exp_q.push_back(entry(32'h0));
    exp_q.push_back(entry(32'h4));
    @(negedge CLK);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    #3;
    check("last_redirect_wins", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge CLK);
    #3;
    check("wrap_addr", imem_req_addr, 32'h0);
    wait_pops(3);
    out_ready = 1'b0;
    check("wrap_drain", 32'(exp_q.size()), 0);

    // Reset mid-burst with the queue full.
    apply_reset();
    mem_lat = 1;
    repeat (8) @(negedge CLK);
    #3;
    check("burst_full_out_valid", 32'(out_valid), 1);
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    check("midrst_req_valid", 32'(imem_req_valid), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_pc", out_pc, 0);
    check("midrst_out_pc4", out_pc4, 0);
    check("midrst_out_instr", out_instruction, 0);
    repeat (2) @(negedge CLK);
    exp_q.delete();
    pop_cnt      = 0;
    req_fire_cnt = 0;
    #1;
    RESET = 1'b1;
    exp_q.push_back(entry(32'h0));
    exp_q.push_back(entry(32'h4));
    out_ready = 1'b1;
    #2;
    check("resume_addr", imem_req_addr, 32'h0);
    wait_pops(2);
    out_ready = 1'b0;
    check("resume_drain", 32'(exp_q.size()), 0);

    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
